// File: rtl/lsu_mem_stage_if.sv
// Bundle of the upstream (EX/MEM) handshake, the downstream (WB) handshake
// and the split request/response data bus seen by the load/store stage.
// The stage uses the slave modport; whatever surrounds it uses master.
//
// Handshake rule for every valid/ready pair in this bundle: a transfer
// happens on the rising clock edge where valid and ready are both high. Once
// raised, valid and its payload hold unchanged until that edge. Ready may
// rise or fall at any time and never waits on a later valid. The read and
// write responses have no ready: they are single-cycle pulses that the
// stage takes only while it is waiting for them.
interface lsu_mem_stage_if #(
  parameter int XLEN = 64,
  parameter int SB_W = 40
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_addr;
  logic [XLEN-1:0]   in_wdata;
  logic [2:0]        in_memop;
  logic              in_memrd;
  logic              in_memwr;
  logic [SB_W-1:0]   in_sb;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_alures;
  logic [SB_W-1:0]   out_sb;
  logic [XLEN-1:0]   out_dataout;
  logic              out_misalign;
  logic              out_buserr;

  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [XLEN-1:0]   rd_addr;
  logic              rd_resp_valid;
  logic [XLEN-1:0]   rd_resp_data;
  logic              rd_resp_err;

  logic              wr_req_valid;
  logic              wr_req_ready;
  logic [XLEN-1:0]   wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic [XLEN/8-1:0] wr_strb;
  logic              wr_resp_valid;
  logic              wr_resp_err;

  modport slave (
    input  in_valid, in_addr, in_wdata, in_memop, in_memrd, in_memwr, in_sb,
    output in_ready,
    output out_valid, out_alures, out_sb, out_dataout, out_misalign, out_buserr,
    input  out_ready,
    output rd_req_valid, rd_addr,
    input  rd_req_ready, rd_resp_valid, rd_resp_data, rd_resp_err,
    output wr_req_valid, wr_addr, wr_data, wr_strb,
    input  wr_req_ready, wr_resp_valid, wr_resp_err
  );

  modport master (
    output in_valid, in_addr, in_wdata, in_memop, in_memrd, in_memwr, in_sb,
    input  in_ready,
    input  out_valid, out_alures, out_sb, out_dataout, out_misalign, out_buserr,
    output out_ready,
    input  rd_req_valid, rd_addr,
    output rd_req_ready, rd_resp_valid, rd_resp_data, rd_resp_err,
    input  wr_req_valid, wr_addr, wr_data, wr_strb,
    output wr_req_ready, wr_resp_valid, wr_resp_err
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store stage between the EX/MEM and WB pipeline registers. Takes one
// instruction per handshake. Loads and stores run one split request/response
// bus transaction on an 8-byte aligned bus. Misaligned accesses and all
// non-memory ops finish without touching the bus. The result is held for WB
// with valid/ready. dbg_state exposes the FSM state for observation.
module lsu_mem_stage #(
  parameter int XLEN = 64,
  parameter int SB_W = 40
) (
  input  logic                clk,
  input  logic                rst,
  lsu_mem_stage_if.slave      bus,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RREQ  = 3'd1,
    S_RWAIT = 3'd2,
    S_WREQ  = 3'd3,
    S_WRESP = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [2:0]        memop_q;
  logic [SB_W-1:0]   sb_q;
  logic [XLEN-1:0]   dataout_q;
  logic              misalign_q;
  logic              buserr_q;

  logic              accept;
  logic              in_mis;
  logic [XLEN-1:0]   lane;
  logic [XLEN-1:0]   load_ext;
  logic [XLEN/8-1:0] strb_base;

  // A new instruction can enter when idle, or when the held result leaves
  // on this same edge (back-to-back handoff with no bubble).
  assign bus.in_ready = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Misalignment only matters for memory ops: a halfword, word or doubleword
  // whose address is not a multiple of its size would cross a bus beat.
  always_comb begin
    in_mis = 1'b0;
    case (bus.in_memop[1:0])
      2'd1:    in_mis = bus.in_addr[0];
      2'd2:    in_mis = |bus.in_addr[1:0];
      2'd3:    in_mis = |bus.in_addr[2:0];
      default: in_mis = 1'b0;
    endcase
    in_mis = in_mis && (bus.in_memrd || bus.in_memwr);
  end

  // Move the addressed bytes of the response down to bit 0, then sign- or
  // zero-extend. memop[2] set means unsigned.
  always_comb begin
    lane     = bus.rd_resp_data >> {addr_q[2:0], 3'b000};
    load_ext = lane;
    case (memop_q[1:0])
      2'd0:    load_ext = {{(XLEN-8){lane[7] & ~memop_q[2]}}, lane[7:0]};
      2'd1:    load_ext = {{(XLEN-16){lane[15] & ~memop_q[2]}}, lane[15:0]};
      2'd2:    load_ext = {{(XLEN-32){lane[31] & ~memop_q[2]}}, lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  // Byte strobes for the access size before they are moved to the address lane.
  always_comb begin
    strb_base = '0;
    case (memop_q[1:0])
      2'd0:    strb_base = (XLEN/8)'(8'h01);
      2'd1:    strb_base = (XLEN/8)'(8'h03);
      2'd2:    strb_base = (XLEN/8)'(8'h0F);
      default: strb_base = (XLEN/8)'(8'hFF);
    endcase
  end

  // The bus requests and WB outputs are decoded from the state and the
  // latched instruction only. They cannot change while a request or a
  // result waits for its ready.
  assign bus.rd_req_valid = (state == S_RREQ);
  assign bus.rd_addr      = {addr_q[XLEN-1:3], 3'b000};
  assign bus.wr_req_valid = (state == S_WREQ);
  assign bus.wr_addr      = {addr_q[XLEN-1:3], 3'b000};
  assign bus.wr_data      = wdata_q << {addr_q[2:0], 3'b000};
  assign bus.wr_strb      = strb_base << addr_q[2:0];

  assign bus.out_valid    = (state == S_DONE);
  assign bus.out_alures   = addr_q;
  assign bus.out_sb       = sb_q;
  assign bus.out_dataout  = dataout_q;
  assign bus.out_misalign = misalign_q;
  assign bus.out_buserr   = buserr_q;
  assign dbg_state        = state;

  // Main FSM. It latches each accepted instruction, runs its bus transaction
  // and holds the finished result until WB takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      memop_q    <= '0;
      sb_q       <= '0;
      dataout_q  <= '0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            addr_q     <= bus.in_addr;
            wdata_q    <= bus.in_wdata;
            memop_q    <= bus.in_memop;
            sb_q       <= bus.in_sb;
            dataout_q  <= '0;
            buserr_q   <= 1'b0;
            misalign_q <= in_mis;
            // A store takes priority when both load and store are set.
            if (in_mis)             state <= S_DONE;
            else if (bus.in_memwr)  state <= S_WREQ;
            else if (bus.in_memrd)  state <= S_RREQ;
            else                    state <= S_DONE;
          end else if (state == S_DONE && bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        S_RREQ: begin
          if (bus.rd_req_ready) state <= S_RWAIT;
        end
        S_RWAIT: begin
          if (bus.rd_resp_valid) begin
            dataout_q <= load_ext;
            buserr_q  <= bus.rd_resp_err;
            state     <= S_DONE;
          end
        end
        S_WREQ: begin
          if (bus.wr_req_ready) state <= S_WRESP;
        end
        S_WRESP: begin
          if (bus.wr_resp_valid) begin
            dataout_q <= '0;
            buserr_q  <= bus.wr_resp_err;
            state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: a vector table of single instructions with a
// reactive bus responder, a randomized load loop with its own extension
// model, and hand-written back-pressure and reset sequences.
module tb_lsu_mem_stage;
  localparam int XLEN = 64;
  localparam int SB_W = 40;
  localparam int EW   = XLEN + XLEN + SB_W + 2;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  memop;
    bit          memrd;
    bit          memwr;
    logic [39:0] sb;
    int          req_delay;
    int          resp_delay;
    logic [63:0] resp_data;
    bit          resp_err;
    logic [63:0] exp_dataout;
    bit          exp_misalign;
    bit          exp_buserr;
    logic [63:0] exp_bus_addr;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_strb;
    int          exp_lat;
  } vec_t;

  logic          clk;
  logic          rst;
  logic [2:0]    dbg_state;
  int            n_checks;
  int            n_fail;
  logic [EW-1:0] exp_q[$];
  vec_t          vecs[14];

  lsu_mem_stage_if #(.XLEN(XLEN), .SB_W(SB_W)) bus ();

  lsu_mem_stage #(.XLEN(XLEN), .SB_W(SB_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] pack_exp(logic [63:0] a, logic [63:0] d,
                                             logic [39:0] sb, logic m, logic e);
    return {a, d, sb, m, e};
  endfunction

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] dut_out();
    return pack_exp(bus.out_alures, bus.out_dataout, bus.out_sb,
                    bus.out_misalign, bus.out_buserr);
  endfunction

  // Pop the oldest expected result and compare it with the presented output.
  task automatic check_out(input string name);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: output with empty expected queue, got %h", name, dut_out());
    end else begin
      e = exp_q.pop_front();
      chk(name, dut_out(), e);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid      = 1'b0;
    bus.in_addr       = '0;
    bus.in_wdata      = '0;
    bus.in_memop      = '0;
    bus.in_memrd      = 1'b0;
    bus.in_memwr      = 1'b0;
    bus.in_sb         = '0;
    bus.out_ready     = 1'b1;
    bus.rd_req_ready  = 1'b0;
    bus.rd_resp_valid = 1'b0;
    bus.rd_resp_data  = '0;
    bus.rd_resp_err   = 1'b0;
    bus.wr_req_ready  = 1'b0;
    bus.wr_resp_valid = 1'b0;
    bus.wr_resp_err   = 1'b0;
  endtask

  // Drive one instruction and play the memory side: each negedge the bench
  // looks at the outputs and sets the inputs for the next rising edge.
  task automatic run_vec(input vec_t v, input string name);
    bit in_pend, rd_pend, wr_pend, rs_pend, rd_hs, wr_hs, sent, done;
    int req_wait, resp_wait, acc_cyc;
    in_pend = 0; rd_pend = 0; wr_pend = 0; rs_pend = 0;
    rd_hs = 0; wr_hs = 0; sent = 0; done = 0;
    req_wait = 0; resp_wait = 0; acc_cyc = -1;
    exp_q.push_back(pack_exp(v.addr, v.exp_dataout, v.sb, v.exp_misalign, v.exp_buserr));
    bus.in_valid  = 1'b1;
    bus.in_addr   = v.addr;
    bus.in_wdata  = v.wdata;
    bus.in_memop  = v.memop;
    bus.in_memrd  = v.memrd;
    bus.in_memwr  = v.memwr;
    bus.in_sb     = v.sb;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (in_pend) begin bus.in_valid = 1'b0; in_pend = 0; end
      if (rd_pend) begin bus.rd_req_ready = 1'b0; rd_pend = 0; rd_hs = 1; end
      if (wr_pend) begin bus.wr_req_ready = 1'b0; wr_pend = 0; wr_hs = 1; end
      if (rs_pend) begin bus.rd_resp_valid = 1'b0; bus.wr_resp_valid = 1'b0; rs_pend = 0; end
      if (bus.out_valid && acc_cyc >= 0) begin
        check_out({name, " result"});
        if (v.exp_lat > 0) chk({name, " latency"}, cyc - acc_cyc, v.exp_lat);
        done = 1;
      end
      if (bus.rd_req_valid) begin
        chk({name, " rd_addr"}, bus.rd_addr, v.exp_bus_addr);
        if (!v.memrd || v.memwr || v.exp_misalign) begin
          n_checks++; n_fail++;
          $display("FAIL %s unexpected read: got rd_req_valid=1 expected 0", name);
        end
        if (req_wait >= v.req_delay) begin bus.rd_req_ready = 1'b1; rd_pend = 1; end
        else req_wait++;
      end
      if (bus.wr_req_valid) begin
        chk({name, " wr_addr"}, bus.wr_addr, v.exp_bus_addr);
        chk({name, " wr_data"}, bus.wr_data, v.exp_wdata);
        chk({name, " wr_strb"}, bus.wr_strb, v.exp_strb);
        if (!v.memwr || v.exp_misalign) begin
          n_checks++; n_fail++;
          $display("FAIL %s unexpected write: got wr_req_valid=1 expected 0", name);
        end
        if (req_wait >= v.req_delay) begin bus.wr_req_ready = 1'b1; wr_pend = 1; end
        else req_wait++;
      end
      if ((rd_hs || wr_hs) && !sent) begin
        if (resp_wait >= v.resp_delay) begin
          if (rd_hs) begin
            bus.rd_resp_valid = 1'b1;
            bus.rd_resp_data  = v.resp_data;
            bus.rd_resp_err   = v.resp_err;
          end else begin
            bus.wr_resp_valid = 1'b1;
            bus.wr_resp_err   = v.resp_err;
          end
          sent = 1; rs_pend = 1;
        end else resp_wait++;
      end
      if (bus.in_valid && bus.in_ready) begin in_pend = 1; acc_cyc = cyc; end
      if (!done) @(negedge clk);
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: got no out_valid within 60 cycles, expected a result", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    int   sz, nb, lane;
    logic [63:0] data, mask, val;

    n_checks = 0;
    n_fail   = 0;
    // addr, wdata, memop, rd, wr, sb, reqd, respd, resp_data, err, exp_dataout, mis, berr, bus_addr, exp_wdata, strb, lat
    vecs[0]  = '{64'h1234, 64'h0, 3'b010, 0, 0, 40'hAA_0000_0001, 0, 0, 64'h0, 0, 64'h0, 0, 0, 64'h0, 64'h0, 8'h00, 1};
    vecs[1]  = '{64'h8000_0003, 64'h0, 3'b000, 1, 0, 40'h01, 0, 0, 64'h0000_0000_80FF_0000, 0, 64'hFFFF_FFFF_FFFF_FF80, 0, 0, 64'h8000_0000, 64'h0, 8'h00, 0};
    vecs[2]  = '{64'h8000_0003, 64'h0, 3'b100, 1, 0, 40'h02, 1, 1, 64'h0000_0000_80FF_0000, 0, 64'h80, 0, 0, 64'h8000_0000, 64'h0, 8'h00, 0};
    vecs[3]  = '{64'h8000_0006, 64'hBEEF, 3'b001, 0, 1, 40'h03, 0, 0, 64'h0, 0, 64'h0, 0, 0, 64'h8000_0000, 64'hBEEF_0000_0000_0000, 8'hC0, 0};
    vecs[4]  = '{64'h8000_0005, 64'h0, 3'b010, 1, 0, 40'h04, 0, 0, 64'h0, 0, 64'h0, 1, 0, 64'h0, 64'h0, 8'h00, 1};
    vecs[5]  = '{64'h8000_0008, 64'h0, 3'b011, 1, 0, 40'h05, 5, 1, 64'h1122_3344_5566_7788, 1, 64'h1122_3344_5566_7788, 0, 1, 64'h8000_0008, 64'h0, 8'h00, 0};
    vecs[6]  = '{64'h1000_0002, 64'h0, 3'b101, 1, 0, 40'h06, 0, 2, 64'h0000_0000_8001_0000, 0, 64'h8001, 0, 0, 64'h1000_0000, 64'h0, 8'h00, 0};
    vecs[7]  = '{64'h1000_0002, 64'h0, 3'b001, 1, 0, 40'h07, 2, 0, 64'h0000_0000_8001_0000, 0, 64'hFFFF_FFFF_FFFF_8001, 0, 0, 64'h1000_0000, 64'h0, 8'h00, 0};
    vecs[8]  = '{64'h2000_0004, 64'h0, 3'b110, 1, 0, 40'h08, 0, 0, 64'hDEAD_BEEF_0000_0000, 0, 64'hDEAD_BEEF, 0, 0, 64'h2000_0000, 64'h0, 8'h00, 0};
    vecs[9]  = '{64'h2000_0004, 64'h0, 3'b010, 1, 0, 40'h09, 0, 0, 64'hDEAD_BEEF_0000_0000, 0, 64'hFFFF_FFFF_DEAD_BEEF, 0, 0, 64'h2000_0000, 64'h0, 8'h00, 0};
    vecs[10] = '{64'h3000_0000, 64'h0123_4567_89AB_CDEF, 3'b011, 0, 1, 40'h0A, 1, 2, 64'h0, 1, 64'h0, 0, 1, 64'h3000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 0};
    vecs[11] = '{64'h3000_0004, 64'hFFFF_FFFF_1122_3344, 3'b010, 0, 1, 40'h0B, 0, 0, 64'h0, 0, 64'h0, 0, 0, 64'h3000_0000, 64'h1122_3344_0000_0000, 8'hF0, 0};
    vecs[12] = '{64'h3000_0001, 64'h55, 3'b001, 0, 1, 40'h0C, 0, 0, 64'h0, 0, 64'h0, 1, 0, 64'h0, 64'h0, 8'h00, 1};
    vecs[13] = '{64'h4000_0001, 64'h5A, 3'b000, 1, 1, 40'h0D, 0, 0, 64'h0, 0, 64'h0, 0, 0, 64'h4000_0000, 64'h5A00, 8'h02, 0};

    // Reset: everything must come up cleared and idle.
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset req valids", {bus.rd_req_valid, bus.wr_req_valid}, 0);
    chk("reset outputs", dut_out(), 0);
    chk("reset state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Random aligned loads of every size, checked against a mask-based model.
    for (int i = 0; i < 12; i++) begin
      sz   = $urandom_range(0, 3);
      nb   = 1 << sz;
      lane = $urandom_range(0, 8 / nb - 1) * nb;
      data = {$urandom, $urandom};
      v = vecs[1];
      v.memop      = {1'($urandom_range(0, 1)), 2'(sz)};
      v.addr       = 64'h5000_0000 + 64'(lane);
      v.sb         = 40'($urandom);
      v.req_delay  = $urandom_range(0, 3);
      v.resp_delay = $urandom_range(0, 3);
      v.resp_data  = data;
      v.resp_err   = 1'($urandom_range(0, 1));
      mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << (8 * nb)) - 64'h1);
      val  = (data >> (8 * lane)) & mask;
      if (!v.memop[2] && val[8 * nb - 1]) val = val | ~mask;
      v.exp_dataout  = val;
      v.exp_buserr   = v.resp_err;
      v.exp_bus_addr = 64'h5000_0000;
      run_vec(v, $sformatf("rand%0d", i));
    end

    // Back-pressure for 3 cycles, then a back-to-back handoff.
    exp_q.push_back(pack_exp(64'hA5A5, 64'h0, 40'h11, 1'b0, 1'b0));
    exp_q.push_back(pack_exp(64'h5A5A, 64'h0, 40'h22, 1'b0, 1'b0));
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_addr   = 64'hA5A5;
    bus.in_sb     = 40'h11;
    @(negedge clk);
    bus.in_addr = 64'h5A5A;
    bus.in_sb   = 40'h22;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d out_valid", i), bus.out_valid, 1);
      chk($sformatf("stall%0d in_ready", i), bus.in_ready, 0);
      chk($sformatf("stall%0d hold", i), dut_out(), exp_q[0]);
      if (i < 2) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    check_out("stall release A");
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b out_valid", bus.out_valid, 1);
    check_out("b2b B");
    @(negedge clk);
    chk("b2b back to idle", bus.out_valid, 0);

    // Reset while waiting for a read response; a late response is ignored.
    bus.in_valid     = 1'b1;
    bus.in_addr      = 64'h6000_0000;
    bus.in_memop     = 3'b010;
    bus.in_memrd     = 1'b1;
    bus.in_sb        = 40'h33;
    bus.rd_req_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rstseq rd_req_valid", bus.rd_req_valid, 1);
    bus.rd_req_ready = 1'b1;
    @(negedge clk);
    bus.rd_req_ready = 1'b0;
    chk("rstseq in RWAIT", dbg_state, 2);
    rst = 1'b1;
    #1;
    chk("rstseq async idle", dbg_state, 0);
    chk("rstseq outputs cleared", {bus.out_valid, bus.rd_req_valid, dut_out()}, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.rd_resp_valid = 1'b1;
    bus.rd_resp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    bus.rd_resp_valid = 1'b0;
    chk("rstseq late resp ignored", {bus.out_valid, dbg_state, bus.out_dataout}, 0);
    idle_inputs();
    @(negedge clk);
    run_vec(vecs[0], "after reset alu");

    chk("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
